// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the inverse SubBytes datapath.
//   - aes_state_t / aes_word_t : 128-bit state, 32-bit word
//   - inv_sb_state_e           : controller states (idle, busy, done)
//   - InvSbox / inv_sbox()     : 256x8 inverse S-box table and lookup helper
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } inv_sb_state_e;

    // Indexed by the input byte value; entry 0 is the first element.
    localparam logic [7:0] InvSbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSbox[b];
    endfunction

endpackage

// File: rtl/inv_sub_word.sv
// inv_sub_word: combinational inverse S-box substitution of one 32-bit word.
//   i_word : input word (four bytes)
//   o_word : each byte replaced by its inverse S-box value, same positions
import aes_pkg::*;

module inv_sub_word (
    input  aes_word_t i_word,
    output aes_word_t o_word
);

    always_comb begin
        o_word = '0;
        for (int i = 0; i < 4; i++) begin
            o_word[8*i +: 8] = inv_sbox(i_word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes over a 128-bit state, one 32-bit word per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_state is latched on acceptance
//   in_state             : state to transform, byte i at [127-8i -: 8]
//   out_valid / out_ready: output handshake; out_state held until accepted
//   out_state            : inverse-substituted state, same byte ordering
//   busy                 : high whenever an operation is in progress or pending
import aes_pkg::*;

module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    inv_sb_state_e r_state;
    inv_sb_state_e w_state_next;
    logic [1:0]    r_wcnt;
    aes_state_t    r_in;
    aes_state_t    r_res;
    aes_word_t     w_word_in;
    aes_word_t     w_word_out;
    logic          w_accept;

    assign w_accept = in_valid && (r_state == StIdle);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StBusy;
            StBusy:  if (r_wcnt == 2'd3) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Word 0 is the most significant word of the state.
    always_comb begin
        w_word_in = '0;
        unique case (r_wcnt)
            2'd0: w_word_in = r_in[127:96];
            2'd1: w_word_in = r_in[95:64];
            2'd2: w_word_in = r_in[63:32];
            2'd3: w_word_in = r_in[31:0];
            default: w_word_in = '0;
        endcase
    end

    // Single substitution unit shared across the four words.
    inv_sub_word u_inv_sub_word (
        .i_word (w_word_in),
        .o_word (w_word_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_wcnt  <= 2'd0;
            r_in    <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_in   <= in_state;
                r_wcnt <= 2'd0;
            end else if (r_state == StBusy) begin
                unique case (r_wcnt)
                    2'd0: r_res[127:96] <= w_word_out;
                    2'd1: r_res[95:64]  <= w_word_out;
                    2'd2: r_res[63:32]  <= w_word_out;
                    2'd3: r_res[31:0]   <= w_word_out;
                    default: r_res      <= r_res;
                endcase
                // Wraps from 3 back to 0 on the final word.
                r_wcnt <= r_wcnt + 2'd1;
            end
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign out_state = r_res;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: self-checking bench for inv_sub_bytes. The reference inverse
// S-box is derived from GF(2^8) inversion plus the AES affine map, then inverted.
module tb_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] ref_inv [256];

    inv_sub_bytes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    task automatic build_ref();
        logic [7:0] xb;
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            ref_inv[s] = xb;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = ref_inv[st[127-8*i -: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After an accepting edge: measure latency, check result, complete handshake.
    task automatic finish_op(input logic [127:0] exp, input int hold, input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 16) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        out_ready = 1'b0;
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, out_state, exp);
        repeat (hold) tick();
        chk({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 128'(in_ready), 128'd1);
        chk({tag, "_valid_after"}, 128'(out_valid), 128'd0);
    endtask

    task automatic transact(input logic [127:0] st, input logic [127:0] exp, input int hold,
                            input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_idle_wait"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        in_state = rand128();
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        finish_op(exp, hold, tag);
    endtask

    initial begin
        logic [127:0] st;
        logic [127:0] exp;
        int           lat;
        int           perm [256];
        int           tmp;
        int           j;

        build_ref();

        // Reset state while rst_n is held low.
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst_n = 1'b1;
        tick();

        // Known-answer vector.
        transact(128'h637c777bf26b6fc53001672bfed7ab76,
                 128'h000102030405060708090a0b0c0d0e0f, 0, "kat");

        // Back-to-back: second state waits on in_valid until the block is idle.
        in_valid = 1'b1;
        in_state = {16{8'h63}};
        tick();
        in_state = {16{8'h00}};
        lat = 0;
        while (!out_valid && lat < 16) begin
            tick();
            lat++;
        end
        chk("b2b_first_latency", 128'(lat), 128'd4);
        chk("b2b_first_data", out_state, {16{8'h00}});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b_idle_between", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_second_busy", 128'(busy), 128'd1);
        chk("b2b_result_retained", out_state, {16{8'h00}});
        finish_op({16{8'h52}}, 0, "b2b_second");

        // Long DONE stall with spurious in_valid traffic.
        st  = rand128();
        exp = model(st);
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 16) begin
            tick();
            lat++;
        end
        chk("stall_latency", 128'(lat), 128'd4);
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_state  = rand128();
            out_ready = 1'b0;
            tick();
            chk("stall_valid", 128'(out_valid), 128'd1);
            chk("stall_data", out_state, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_idle", 128'(in_ready), 128'd1);
        chk("stall_release_data", out_state, exp);

        // Reset mid-operation, after two words have been written.
        in_valid = 1'b1;
        in_state = rand128();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_out_state", out_state, 128'd0);
        tick();
        rst_n = 1'b1;
        st = {32'h16ed5200, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        chk("postrst_accept", 128'(busy), 128'd1);
        finish_op(model(st), 1, "postrst");
        chk("postrst_top_word", {96'd0, out_state[127:96]}, {96'd0, 32'hff534852});

        // Exhaustive byte coverage: four shuffled passes over all 256 values.
        for (int t = 0; t < 64; t++) begin
            if (t % 16 == 0) begin
                for (int i = 0; i < 256; i++) perm[i] = i;
                for (int i = 255; i > 0; i--) begin
                    j       = int'($urandom_range(0, i));
                    tmp     = perm[i];
                    perm[i] = perm[j];
                    perm[j] = tmp;
                end
            end
            st = '0;
            for (int b = 0; b < 16; b++) begin
                st[127-8*b -: 8] = 8'(perm[(t % 16) * 16 + b]);
            end
            transact(st, model(st), int'($urandom_range(0, 3)), "exh");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
